// File: rtl/key_pkg.sv
// key_pkg: definitions shared by the front-panel key conditioner.
// It provides:
//   - the per-key debounce FSM state type;
//   - symbolic indices for the three keys (Pulse, QD, CLR);
//   - the default timing and polarity constants that parameterise key_conditioner.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } key_state_e;

  localparam int KEY_PULSE = 0;
  localparam int KEY_QD    = 1;
  localparam int KEY_CLR   = 2;

  localparam int                      NUM_KEYS_DEF         = 3;
  localparam logic [NUM_KEYS_DEF-1:0] ACTIVE_LOW_MASK_DEF  = 3'b100;
  localparam int                      DEBOUNCE_MS_DEF      = 20;
  localparam int                      REPEAT_DELAY_MS_DEF  = 500;
  localparam int                      REPEAT_PERIOD_MS_DEF = 100;

endpackage

// File: rtl/key_debounce.sv
// key_debounce: conditions one key.
// The key passes through a 2-flop synchroniser and then a debounce FSM.
// The FSM produces a clean level plus single-cycle press, release and auto-repeat pulses.
// Optional feature macro: KEY_AUTOREPEAT_EN. When it is undefined, the hold counter
// does not exist and repeat_o is tied low.
// Ports:
//   clk_i     - 1 kHz clock (1 cycle = 1 ms)
//   rst_i     - synchronous active-high reset
//   key_i     - raw key, already polarity-corrected (1 = pressed), asynchronous
//   level_o   - debounced pressed state
//   press_o   - 1-cycle pulse on an accepted press
//   release_o - 1-cycle pulse on an accepted release
//   repeat_o  - 1-cycle auto-repeat pulse while held
module key_debounce
  import key_pkg::*;
#(
  parameter int DEBOUNCE_MS = DEBOUNCE_MS_DEF
`ifdef KEY_AUTOREPEAT_EN
  , parameter int REPEAT_DELAY_MS  = REPEAT_DELAY_MS_DEF
  , parameter int REPEAT_PERIOD_MS = REPEAT_PERIOD_MS_DEF
`endif
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic repeat_o
);

  // cnt runs 0..DEBOUNCE_MS-1 while waiting, so the decision edge is the
  // DEBOUNCE_MS-th FSM cycle after entering a wait state.
  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_MS - 1);

  logic       sync1_q;
  logic       sync_q;
  key_state_e state_q;
  logic [7:0] cnt_q;
  logic       level_q;
  logic       press_q;
  logic       release_q;

`ifdef KEY_AUTOREPEAT_EN
  localparam int HOLD_MAX = (REPEAT_DELAY_MS > REPEAT_PERIOD_MS) ? REPEAT_DELAY_MS
                                                                 : REPEAT_PERIOD_MS;
  localparam int HOLD_W   = $clog2(HOLD_MAX + 1);
  localparam logic [HOLD_W-1:0] DELAY_LAST  = HOLD_W'(REPEAT_DELAY_MS - 1);
  localparam logic [HOLD_W-1:0] PERIOD_LAST = HOLD_W'(REPEAT_PERIOD_MS - 1);

  logic [HOLD_W-1:0] hold_cnt_q;
  logic              rep_armed_q;  // first repeat already issued: use period spacing
  logic              repeat_q;
  logic              rep_hit;

  assign rep_hit  = (hold_cnt_q == (rep_armed_q ? PERIOD_LAST : DELAY_LAST));
  assign repeat_o = repeat_q;
`else
  assign repeat_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q     <= 1'b0;
      sync_q      <= 1'b0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      level_q     <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
      hold_cnt_q  <= '0;
      rep_armed_q <= 1'b0;
      repeat_q    <= 1'b0;
`endif
    end else begin
      sync1_q   <= key_i;
      sync_q    <= sync1_q;
      press_q   <= 1'b0;
      release_q <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
      repeat_q  <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (sync_q) begin
            state_q <= PRESS_WAIT;
            cnt_q   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!sync_q) begin
            state_q <= IDLE;
          end else if (cnt_q == CNT_LAST) begin
            state_q     <= HELD;
            press_q     <= 1'b1;
            level_q     <= 1'b1;
`ifdef KEY_AUTOREPEAT_EN
            hold_cnt_q  <= '0;
            rep_armed_q <= 1'b0;
`endif
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        HELD: begin
          if (!sync_q) begin
            state_q <= RELEASE_WAIT;
            cnt_q   <= '0;
          end
`ifdef KEY_AUTOREPEAT_EN
          else if (rep_hit) begin
            repeat_q    <= 1'b1;
            hold_cnt_q  <= '0;
            rep_armed_q <= 1'b1;
          end else if (hold_cnt_q != '1) begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
          end
`endif
        end
        RELEASE_WAIT: begin
          // hold_cnt is deliberately left untouched here so a release bounce
          // only pauses the repeat timing.
          if (sync_q) begin
            state_q <= HELD;
          end else if (cnt_q == CNT_LAST) begin
            state_q     <= IDLE;
            release_q   <= 1'b1;
            level_q     <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
            hold_cnt_q  <= '0;
            rep_armed_q <= 1'b0;
`endif
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/key_conditioner.sv
// key_conditioner: front-panel push-button conditioner for the clock/alarm/stopwatch top.
// Per key it corrects polarity, then uses one key_debounce instance.
// key_event (press | repeat) is the digit-step strobe for the top level.
// Optional feature macro: KEY_AUTOREPEAT_EN enables auto-repeat. When it is undefined,
// key_repeat is 0 and the REPEAT_* parameters are only range-checked.
// Ports:
//   clk_1khz    - sole clock, 1 kHz
//   switch_clr  - synchronous active-high reset
//   key_raw     - asynchronous raw buttons (bit 0 Pulse, 1 QD, 2 CLR)
//   key_level   - debounced pressed state, active-high
//   key_press   - 1-cycle pulse on accepted press
//   key_release - 1-cycle pulse on accepted release
//   key_repeat  - 1-cycle auto-repeat pulse
//   key_event   - key_press | key_repeat
module key_conditioner
  import key_pkg::*;
#(
  parameter int                  NUM_KEYS         = NUM_KEYS_DEF,
  parameter logic [NUM_KEYS-1:0] ACTIVE_LOW_MASK  = NUM_KEYS'(ACTIVE_LOW_MASK_DEF),
  parameter int                  DEBOUNCE_MS      = DEBOUNCE_MS_DEF,
  parameter int                  REPEAT_DELAY_MS  = REPEAT_DELAY_MS_DEF,
  parameter int                  REPEAT_PERIOD_MS = REPEAT_PERIOD_MS_DEF
) (
  input  logic                clk_1khz,
  input  logic                switch_clr,
  input  logic [NUM_KEYS-1:0] key_raw,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_repeat,
  output logic [NUM_KEYS-1:0] key_event
);

  // The 8-bit debounce counter limits DEBOUNCE_MS.
  if (DEBOUNCE_MS < 2 || DEBOUNCE_MS > 255) begin : g_bad_debounce
    $error("key_conditioner: DEBOUNCE_MS must be 2..255");
  end
  if (REPEAT_DELAY_MS < 1 || REPEAT_PERIOD_MS < 1) begin : g_bad_repeat
    $error("key_conditioner: REPEAT_* must be >= 1");
  end

  logic [NUM_KEYS-1:0] key_act;

  assign key_act = key_raw ^ ACTIVE_LOW_MASK;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debounce #(
      .DEBOUNCE_MS(DEBOUNCE_MS)
`ifdef KEY_AUTOREPEAT_EN
      , .REPEAT_DELAY_MS(REPEAT_DELAY_MS)
      , .REPEAT_PERIOD_MS(REPEAT_PERIOD_MS)
`endif
    ) u_deb (
      .clk_i    (clk_1khz),
      .rst_i    (switch_clr),
      .key_i    (key_act[k]),
      .level_o  (key_level[k]),
      .press_o  (key_press[k]),
      .release_o(key_release[k]),
      .repeat_o (key_repeat[k])
    );
  end

  assign key_event = key_press | key_repeat;

endmodule

// File: tb/tb_key_conditioner.sv
module tb_key_conditioner;
  import key_pkg::*;

  localparam int DB    = 20;
  localparam int LAT   = DB + 3;  // from "changed just after edge n" to pulse registered at edge n+LAT
  localparam int K_PRS = 0;
  localparam int K_REL = 1;
  localparam int K_REP = 2;

  logic       clk_1khz = 1'b0;
  logic       switch_clr;
  logic [2:0] key_raw;
  logic [2:0] key_level, key_press, key_release, key_repeat, key_event;

  key_conditioner dut (
    .clk_1khz   (clk_1khz),
    .switch_clr (switch_clr),
    .key_raw    (key_raw),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .key_repeat (key_repeat),
    .key_event  (key_event)
  );

  always #5 clk_1khz = ~clk_1khz;

  int cyc = 0;
  always @(posedge clk_1khz) cyc <= cyc + 1;

  typedef struct {
    int at;
    int key;
    int kind;
  } ev_t;
  ev_t sb[$];

  int tests = 0;
  int fails = 0;

  task automatic check_vec(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic expect_ev(input int key, input int kind, input int at);
    ev_t e;
    e.at = at;
    e.key = key;
    e.kind = kind;
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_1khz);
    #1;
  endtask

  // Pulse monitor: expected events due this cycle are popped from the scoreboard
  // and compared against every pulse output; any unexpected pulse also fails.
  logic [2:0] ep, er, et;
  always @(negedge clk_1khz) begin
    ep = '0;
    er = '0;
    et = '0;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at == cyc) begin
        case (sb[i].kind)
          K_PRS:   ep[sb[i].key] = 1'b1;
          K_REL:   er[sb[i].key] = 1'b1;
          default: et[sb[i].key] = 1'b1;
        endcase
        sb.delete(i);
      end
    end
    if ((key_press | ep) != 3'b000)   check_vec("press", key_press, ep);
    if ((key_release | er) != 3'b000) check_vec("release", key_release, er);
    if ((key_repeat | et) != 3'b000)  check_vec("repeat", key_repeat, et);
    if ((key_event | ep | et) != 3'b000) check_vec("event", key_event, ep | et);
  end

  int p0;

  initial begin
    // Reset with all keys pressed (CLR is active-low, so pressed = raw 0).
    switch_clr = 1'b1;
    key_raw    = 3'b011;
    step(3);
    check_vec("rst_level", key_level, 3'b000);
    check_vec("rst_press", key_press, 3'b000);
    check_vec("rst_release", key_release, 3'b000);
    check_vec("rst_repeat", key_repeat, 3'b000);
    check_vec("rst_event", key_event, 3'b000);

    // Leave reset with keys still held: simultaneous presses.
    switch_clr = 1'b0;
    for (int k = 0; k < 3; k++) expect_ev(k, K_PRS, cyc + LAT);
    step(LAT - 2);
    check_vec("level_before_press", key_level, 3'b000);
    step(10);
    check_vec("level_all_held", key_level, 3'b111);
    key_raw = 3'b100;
    for (int k = 0; k < 3; k++) expect_ev(k, K_REL, cyc + LAT);
    step(30);
    check_vec("level_all_released", key_level, 3'b000);

    // Clean press of Pulse held 100 cycles.
    key_raw[KEY_PULSE] = 1'b1;
    expect_ev(KEY_PULSE, K_PRS, cyc + LAT);
    step(100);
    check_vec("pulse_held", key_level, 3'b001);
    key_raw[KEY_PULSE] = 1'b0;
    expect_ev(KEY_PULSE, K_REL, cyc + LAT);
    step(LAT - 2);
    check_vec("pulse_level_until_release", key_level, 3'b001);
    step(10);
    check_vec("pulse_released", key_level, 3'b000);

    // QD bounce: toggles every 3 cycles, then held high.
    for (int i = 0; i < 14; i++) begin
      key_raw[KEY_QD] = ~key_raw[KEY_QD];
      step(3);
    end
    check_vec("bounce_no_level", key_level, 3'b000);
    key_raw[KEY_QD] = 1'b1;
    expect_ev(KEY_QD, K_PRS, cyc + LAT);
    step(30);
    check_vec("bounce_held", key_level, 3'b010);
    key_raw[KEY_QD] = 1'b0;
    expect_ev(KEY_QD, K_REL, cyc + LAT);
    step(30);

    // Active-low CLR key.
    key_raw[KEY_CLR] = 1'b0;
    expect_ev(KEY_CLR, K_PRS, cyc + LAT);
    step(30);
    check_vec("clr_held", key_level, 3'b100);
    key_raw[KEY_CLR] = 1'b1;
    expect_ev(KEY_CLR, K_REL, cyc + LAT);
    step(30);
    check_vec("clr_released", key_level, 3'b000);

    // Short glitch while idle is rejected.
    key_raw[KEY_PULSE] = 1'b1;
    step(5);
    key_raw[KEY_PULSE] = 1'b0;
    step(30);
    check_vec("idle_glitch", key_level, 3'b000);

    // Low glitch during HELD: no release, no second press.
    key_raw[KEY_PULSE] = 1'b1;
    expect_ev(KEY_PULSE, K_PRS, cyc + LAT);
    step(30);
    key_raw[KEY_PULSE] = 1'b0;
    step(5);
    key_raw[KEY_PULSE] = 1'b1;
    step(40);
    check_vec("held_glitch", key_level, 3'b001);

    // Reset mid-HELD: no release; still-held key is re-debounced.
    switch_clr = 1'b1;
    step(2);
    check_vec("midreset_level", key_level, 3'b000);
    switch_clr = 1'b0;
    expect_ev(KEY_PULSE, K_PRS, cyc + LAT);
    step(30);
    check_vec("redebounce_level", key_level, 3'b001);
    key_raw[KEY_PULSE] = 1'b0;
    expect_ev(KEY_PULSE, K_REL, cyc + LAT);
    step(30);

    // Long hold of QD: repeats only when the feature is built in.
    key_raw[KEY_QD] = 1'b1;
    p0 = cyc + LAT;
    expect_ev(KEY_QD, K_PRS, p0);
`ifdef KEY_AUTOREPEAT_EN
    for (int r = 0; r < 4; r++) expect_ev(KEY_QD, K_REP, p0 + 500 + 100 * r);
`endif
    step(LAT + 805);
    check_vec("long_hold", key_level, 3'b010);
    key_raw[KEY_QD] = 1'b0;
    expect_ev(KEY_QD, K_REL, cyc + LAT);
    step(40);
    check_vec("final_level", key_level, 3'b000);

    tests++;
    assert (sb.size() == 0) else begin
      fails++;
      $error("FAIL scoreboard_drain observed=%0d pending expected=0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/key_conditioner.md
# key_conditioner

Conditions the raw front-panel push-buttons (Pulse, QD, CLR) before they reach the clock/alarm/stopwatch top level. Each key is synchronised into the 1 kHz domain, debounced, and reduced to a clean level plus single-cycle press/release pulses. An optional auto-repeat generates extra pulses while a key is held, so a held QD key steps a digit continuously. The outputs replace the direct use of raw buttons as clocks in the top level.

## Interface
- `NUM_KEYS`, 3: number of keys; bit 0 = Pulse, bit 1 = QD, bit 2 = CLR.
- `ACTIVE_LOW_MASK`, 3'b100: bit set means that raw key is active-low and is inverted before synchronisation.
- `DEBOUNCE_MS`, 20: cycles of stable input required to accept a press or a release; legal range 2..255.
- `REPEAT_DELAY_MS`, 500: hold time from `key_press` to the first `key_repeat`.
- `REPEAT_PERIOD_MS`, 100: spacing of subsequent `key_repeat` pulses.

- `clk_1khz`  in  1  sole clock, 1 kHz; 1 cycle = 1 ms.
- `switch_clr`  in  1  reset; synchronous, active-high.
- `key_raw`  in  NUM_KEYS  asynchronous raw button inputs.
- `key_level`  out  NUM_KEYS  debounced pressed state, active-high.
- `key_press`  out  NUM_KEYS  1-cycle pulse on an accepted press.
- `key_release`  out  NUM_KEYS  1-cycle pulse on an accepted release.
- `key_repeat`  out  NUM_KEYS  1-cycle auto-repeat pulse.
- `key_event`  out  NUM_KEYS  `key_press | key_repeat`; the signal the top level uses to step digits.

## Operation
- **Input path.** Per key: XOR with `ACTIVE_LOW_MASK`, then a 2-flop synchroniser. The second flop, `sync`, is the only value the FSM sees.
- **Per-key FSM**, with an independent instance per key:
  - IDLE: if `sync`=1, go to PRESS_WAIT and clear `cnt`.
  - PRESS_WAIT: if `sync`=0, return to IDLE with no output. Otherwise increment `cnt`. When `sync` has been 1 for `DEBOUNCE_MS` consecutive FSM cycles, go to HELD, pulse `key_press`, set `key_level`=1, and clear `hold_cnt`.
  - HELD: if `sync`=0, go to RELEASE_WAIT and clear `cnt`.
  - RELEASE_WAIT: if `sync`=1, return to HELD with no new `key_press`. If `sync` has been 0 for `DEBOUNCE_MS` consecutive cycles, go to IDLE, pulse `key_release`, and set `key_level`=0.
- **Counter widths.** `cnt` is 8 bits. `hold_cnt` is wide enough for max(`REPEAT_DELAY_MS`, `REPEAT_PERIOD_MS`) and saturates; it never wraps.
- **Auto-repeat.**
  - `hold_cnt` counts only in HELD, is frozen in RELEASE_WAIT, and is cleared on entry to IDLE.
  - The first `key_repeat` fires `REPEAT_DELAY_MS` cycles after `key_press`.
  - After that, `hold_cnt` reloads and `key_repeat` fires every `REPEAT_PERIOD_MS` cycles.
- **Independence.** Keys are fully independent. Simultaneous presses produce simultaneous pulses on their own bits.
- **Pulse exclusivity.** `key_press`, `key_repeat` and `key_release` never assert together on the same key.

## Timing
- **Reset values.** When `switch_clr`=1 at an edge:
  - All outputs become 0.
  - Synchroniser flops become 0 (after polarity correction, i.e. not pressed).
  - All FSMs go to IDLE; all counters clear.
- **Reset mid-operation.** Reset during HELD emits no `key_release`. If the key is still held after reset, it is re-debounced as a new press.
- **Press latency.** If `key_raw` goes active before edge E0 and stays stable, `key_press` is high for exactly the cycle following edge E0+`DEBOUNCE_MS`+2. This is 2 synchroniser cycles plus 1 IDLE→PRESS_WAIT cycle plus debounce counting.
- **Release latency.** Release latency is identical to press latency.
- **Output registers.** All outputs are registered; there are no combinational paths from `key_raw`.
- **Glitch rejection.** A glitch shorter than `DEBOUNCE_MS` cycles never changes `key_level` and never produces a pulse.

## Configuration
- Macro `KEY_AUTOREPEAT_EN`.
- Defined: the `hold_cnt` logic and `key_repeat` are present as described.
- Undefined:
  - `hold_cnt` is not synthesised.
  - `key_repeat` is tied to 0.
  - `key_event` equals `key_press`.
  - The `REPEAT_*` parameters are accepted but ignored.

## Structure
- **Shared package `key_pkg`:**
  - FSM state typedef (IDLE, PRESS_WAIT, HELD, RELEASE_WAIT).
  - Key index constants `KEY_PULSE`=0, `KEY_QD`=1, `KEY_CLR`=2.
  - Default timing constants.
- **Sub-module `key_debounce`:** one instance per key, generated `NUM_KEYS` times. It holds the synchroniser, FSM, `cnt` and `hold_cnt`.
- **`key_conditioner` itself:** parameter fan-out, polarity XOR, and `key_event` OR only.

## Test plan
- **Reset:** assert `switch_clr` 3 cycles with all keys pressed → all outputs 0; after release of reset, `key_press` is seen 22 cycles later (`DEBOUNCE_MS`=20).
- **Clean press:** clean press of bit 0 held 100 cycles, then released → `key_press[0]` pulses once at edge 22, `key_level[0]` stays high until `key_release[0]` 22 cycles after the release, with no other pulses.
- **Bounce:** bit 1 toggles every 3 cycles for 40 cycles, then is held high → exactly one `key_press[1]`, 22 cycles after the final rising transition.
- **Active-low key:** bit 2 raw driven 0 (active-low) for 30 cycles → `key_press[2]` once; raw driven 1 → `key_release[2]` once.
- **Auto-repeat (`KEY_AUTOREPEAT_EN` defined):** hold bit 1 for 800 cycles after `key_press` → `key_repeat[1]` at +500, +600, +700, +800; `key_event` shows 5 pulses. Without the macro, `key_repeat` stays 0.
- **Release bounce and reset mid-hold:** a 5-cycle low glitch during HELD → no `key_release`, no `key_press`, `hold_cnt` resumes. Reset asserted mid-HELD → no `key_release` is emitted.
